// File: rtl/ols_pkg.sv
// Shared definitions for the logic-analyzer front end: lane count helpers
// and the demux mode encoding.
package ols_pkg;

    localparam logic DEMUX_OFF = 1'b0;
    localparam logic DEMUX_ON  = 1'b1;

    // Lanes per output word: two per clock pair.
    function automatic int unsigned lanes_of(input int unsigned pack);
        return 2 * pack;
    endfunction

    // Width of a counter that must hold 0..LANES inclusive.
    function automatic int unsigned fill_width(input int unsigned pack);
        return $clog2(2 * pack + 1);
    endfunction

endpackage

// File: rtl/sample_demux.sv
// Sample demultiplexer/packer. Captures one (normal) or two (demux: in-phase
// plus 180-degree) CHANNELS-wide samples per enabled clock into a word of
// 2*PACK lanes and emits it with a one-cycle valid strobe. Flush emits a
// zero-padded partial word.
// Ports:
//   clock, resetN       clock and async active-low reset
//   dataInput           rising-edge sample
//   dataInput180        falling-edge sample, already retimed to clock
//   sampleEnable        capture qualifier
//   demuxMode           0 = dataInput only, 1 = both inputs each enabled cycle
//   flush               emit the current partial word
//   dataOutput          packed word, lane 0 in the LSBs and oldest
//   dataValid           one-cycle strobe qualifying dataOutput
module sample_demux
    import ols_pkg::*;
#(
    parameter int unsigned CHANNELS = 16,
    parameter int unsigned PACK     = 2
) (
    input  logic                                   clock,
    input  logic                                   resetN,
    input  logic [CHANNELS-1:0]                    dataInput,
    input  logic [CHANNELS-1:0]                    dataInput180,
    input  logic                                   sampleEnable,
    input  logic                                   demuxMode,
    input  logic                                   flush,
    output logic [CHANNELS*lanes_of(PACK)-1:0]     dataOutput,
    output logic                                   dataValid
);

    localparam int unsigned LANES = lanes_of(PACK);
    localparam int unsigned FW    = fill_width(PACK);

    logic [FW-1:0]                      fill_q, fill_d;
    logic                               mode_q, mode_d;
    logic [LANES-1:0][CHANNELS-1:0]     lane_q, lane_d;
    logic [CHANNELS*LANES-1:0]          data_output_q, data_output_d;
    logic                               data_valid_q, data_valid_d;

    logic                               mode_eff_c;
    logic [FW-1:0]                      fill_next_c;
    logic                               emit_c;
    logic [LANES-1:0]                   we_a_c, we_b_c;
    logic [LANES-1:0][CHANNELS-1:0]     word_c;

    // A new word picks up demuxMode; inside a word the latched mode rules.
    assign mode_eff_c  = (fill_q == '0) ? demuxMode : mode_q;
    assign fill_next_c = sampleEnable
                       ? fill_q + ((mode_eff_c == DEMUX_ON) ? FW'(2) : FW'(1))
                       : fill_q;
    // Capture happens before the emit decision, so flush+enable strobes once.
    assign emit_c      = (fill_next_c == FW'(LANES)) || (flush && (fill_next_c != '0));

    // Per-lane write enables and the zero-padded output view of each lane.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign we_a_c[i] = sampleEnable && (fill_q == FW'(i));
        assign we_b_c[i] = sampleEnable && (mode_eff_c == DEMUX_ON)
                        && ((fill_q + FW'(1)) == FW'(i));
        assign lane_d[i] = we_a_c[i] ? dataInput
                         : (we_b_c[i] ? dataInput180 : lane_q[i]);
        // Stale lanes beyond the fill point must not leak on flush.
        assign word_c[i] = (FW'(i) < fill_next_c) ? lane_d[i] : '0;
    end

    // Next-state for counter, mode and the output register.
    always_comb begin
        fill_d        = fill_next_c;
        mode_d        = mode_eff_c;
        data_output_d = data_output_q;
        data_valid_d  = 1'b0;
        if (emit_c) begin
            fill_d        = '0;
            data_output_d = word_c;
            data_valid_d  = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            fill_q        <= '0;
            mode_q        <= DEMUX_OFF;
            lane_q        <= '0;
            data_output_q <= '0;
            data_valid_q  <= 1'b0;
        end else begin
            fill_q        <= fill_d;
            mode_q        <= mode_d;
            lane_q        <= lane_d;
            data_output_q <= data_output_d;
            data_valid_q  <= data_valid_d;
        end
    end

    assign dataOutput = data_output_q;
    assign dataValid  = data_valid_q;

endmodule

// File: tb/tb_sample_demux.sv
// Bench for sample_demux: PACK=2 instance driven by directed and random
// stimulus against a reference packer model, plus a PACK=1 legacy instance.
module tb_sample_demux;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetN;
    logic [15:0] din, din180;
    logic        en, dm, fl;
    logic [63:0] dout;
    logic        dval;

    logic [15:0] a1, b1;
    logic        en1;
    logic [31:0] dout1;
    logic        dval1;

    sample_demux #(.CHANNELS(16), .PACK(2)) u_dut (
        .clock        (clock),
        .resetN       (resetN),
        .dataInput    (din),
        .dataInput180 (din180),
        .sampleEnable (en),
        .demuxMode    (dm),
        .flush        (fl),
        .dataOutput   (dout),
        .dataValid    (dval)
    );

    sample_demux #(.CHANNELS(16), .PACK(1)) u_dut1 (
        .clock        (clock),
        .resetN       (resetN),
        .dataInput    (a1),
        .dataInput180 (b1),
        .sampleEnable (en1),
        .demuxMode    (1'b1),
        .flush        (1'b0),
        .dataOutput   (dout1),
        .dataValid    (dval1)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp1_q[$];
    int          m_fill;
    logic        m_mode;
    logic [15:0] m_lane[4];
    logic [63:0] last_word;
    logic [31:0] last1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle on the PACK=2 instance, update the model, check output.
    task automatic step(input logic [15:0] a, input logic [15:0] b,
                        input logic e, input logic d, input logic f);
        logic        exp_strobe;
        logic [63:0] w;
        exp_strobe = 1'b0;
        din = a; din180 = b; en = e; dm = d; fl = f;
        if (m_fill == 0) m_mode = d;
        if (e) begin
            m_lane[m_fill] = a;
            m_fill++;
            if (m_mode) begin
                m_lane[m_fill] = b;
                m_fill++;
            end
        end
        if (m_fill == 4 || (f && m_fill > 0)) begin
            w = '0;
            for (int i = 0; i < m_fill; i++) w[i*16 +: 16] = m_lane[i];
            exp_q.push_back(w);
            m_fill     = 0;
            exp_strobe = 1'b1;
        end
        @(posedge clock);
        @(negedge clock);
        check("valid", 64'(dval), 64'(exp_strobe));
        if (dval && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check("word", dout, w);
            last_word = w;
        end else if (!dval) begin
            check("hold", dout, last_word);
        end
    endtask

    // One enabled cycle on the PACK=1 instance.
    task automatic step1(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] w;
        a1 = a; b1 = b; en1 = 1'b1;
        exp1_q.push_back({b, a});
        @(posedge clock);
        @(negedge clock);
        check("p1_valid", 64'(dval1), 64'(1));
        if (dval1 && exp1_q.size() > 0) begin
            w = exp1_q.pop_front();
            check("p1_word", 64'(dout1), 64'(w));
            last1 = w;
        end
    endtask

    initial begin
        resetN = 1'b0;
        din = '0; din180 = '0; en = 1'b0; dm = 1'b0; fl = 1'b0;
        a1 = '0; b1 = '0; en1 = 1'b0;
        m_fill = 0; m_mode = 1'b0; last_word = '0; last1 = '0;
        for (int i = 0; i < 4; i++) m_lane[i] = '0;

        repeat (2) @(negedge clock);
        check("rst_valid", 64'(dval), 64'(0));
        check("rst_data", dout, 64'(0));
        check("rst_valid1", 64'(dval1), 64'(0));
        check("rst_data1", 64'(dout1), 64'(0));
        resetN = 1'b1;
        @(negedge clock);

        // Demux pair A1/B1 then A2/B2.
        step(16'h1111, 16'h2222, 1'b1, 1'b1, 1'b0);
        step(16'h3333, 16'h4444, 1'b1, 1'b1, 1'b0);
        check("demux_word", last_word, 64'h4444_3333_2222_1111);

        // Normal mode with gaps in sampleEnable.
        step(16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        step(16'hDEAD, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        step(16'h0002, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        step(16'h0003, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        step(16'hBEEF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        step(16'h0004, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        check("gap_word", last_word, 64'h0004_0003_0002_0001);

        // Partial word flush, then a flush with nothing buffered.
        step(16'h00AA, 16'h5555, 1'b1, 1'b0, 1'b0);
        step(16'h00BB, 16'h5555, 1'b1, 1'b0, 1'b0);
        step(16'h1234, 16'h5555, 1'b0, 1'b0, 1'b1);
        check("flush_word", last_word, 64'h0000_0000_00BB_00AA);
        step(16'h1234, 16'h5555, 1'b0, 1'b0, 1'b1);

        // Flush coinciding with a capture.
        step(16'h00AA, 16'h5555, 1'b1, 1'b0, 1'b0);
        step(16'h00BB, 16'h5555, 1'b1, 1'b0, 1'b0);
        step(16'h00CC, 16'h5555, 1'b1, 1'b0, 1'b1);
        check("flush_cap_word", last_word, 64'h0000_00CC_00BB_00AA);
        step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Mode drops mid-word: word stays demux, next word is normal.
        step(16'hA001, 16'hB001, 1'b1, 1'b1, 1'b0);
        step(16'hA002, 16'hB002, 1'b1, 1'b0, 1'b0);
        check("mode_hold_word", last_word, 64'hB002_A002_B001_A001);
        step(16'hC001, 16'hD001, 1'b1, 1'b0, 1'b0);
        step(16'hC002, 16'hD002, 1'b1, 1'b0, 1'b0);
        step(16'hC003, 16'hD003, 1'b1, 1'b0, 1'b0);
        step(16'hC004, 16'hD004, 1'b1, 1'b0, 1'b0);
        check("mode_next_word", last_word, 64'hC004_C003_C002_C001);

        // Reset with three lanes filled.
        step(16'h0E01, 16'h0, 1'b1, 1'b0, 1'b0);
        step(16'h0E02, 16'h0, 1'b1, 1'b0, 1'b0);
        step(16'h0E03, 16'h0, 1'b1, 1'b0, 1'b0);
        en = 1'b0;
        #2 resetN = 1'b0;
        #1;
        check("midrst_valid", 64'(dval), 64'(0));
        check("midrst_data", dout, 64'(0));
        m_fill = 0; m_mode = 1'b0; last_word = '0; last1 = '0;
        exp_q.delete();
        @(negedge clock);
        resetN = 1'b1;
        step(16'h0F01, 16'h0, 1'b1, 1'b0, 1'b0);
        step(16'h0F02, 16'h0, 1'b1, 1'b0, 1'b0);
        step(16'h0F03, 16'h0, 1'b1, 1'b0, 1'b0);
        step(16'h0F04, 16'h0, 1'b1, 1'b0, 1'b0);
        check("post_rst_word", last_word, 64'h0F04_0F03_0F02_0F01);

        // Random mix of enables, mode changes and flushes.
        for (int n = 0; n < 80; n++) begin
            step(16'($urandom), 16'($urandom),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 5) == 0));
        end
        step(16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        check("queue_empty", 64'(exp_q.size()), 64'(0));

        // Legacy PACK=1 demux: one word per enabled cycle.
        step1(16'h1234, 16'h5678);
        check("p1_legacy", 64'(last1), 64'h0000_0000_5678_1234);
        for (int n = 0; n < 6; n++) step1(16'($urandom), 16'($urandom));
        en1 = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("p1_idle_valid", 64'(dval1), 64'(0));
        check("p1_idle_hold", 64'(dout1), 64'(last1));
        check("p1_queue_empty", 64'(exp1_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sample_demux.md
# sample_demux

Parametrised sample demultiplexer/packer for the logic-analyzer front end, between the input synchroniser and the trigger/sampler stage. It captures one (normal mode) or two (demux mode: in-phase plus 180°-phase) CHANNELS-wide samples per enabled clock. It packs them into a wide output word of 2·PACK lanes and emits that word with a single-cycle valid strobe. A flush input emits a partially filled word.

## Interface
- CHANNELS, 16, width of one sample (one lane)
- PACK, 2, clock-pairs per output word; lanes per word LANES = 2·PACK; legal PACK ≥ 1
- clock  in  1  sole clock, rising edge
- resetN  in  1  asynchronous, active-low reset
- dataInput  in  CHANNELS  sample captured on the rising edge
- dataInput180  in  CHANNELS  sample captured on the falling edge, already retimed to clock
- sampleEnable  in  1  capture qualifier from the sample-rate divider
- demuxMode  in  1  0 = dataInput only, 1 = dataInput and dataInput180 each enabled cycle
- flush  in  1  emit the current partial word, zero-padded
- dataOutput  out  CHANNELS·LANES  packed word; lane 0 in the LSBs and oldest
- dataValid  out  1  one-cycle strobe; dataOutput valid while high

## Operation
- Lane counter `fill` runs 0..LANES and counts lanes written in the current word.
- The mode is latched into `modeQ` when fill = 0. demuxMode changes while fill ≠ 0 are ignored until the next word starts.
- sampleEnable with modeQ = 0: dataInput → lane fill; fill += 1.
- sampleEnable with modeQ = 1: dataInput → lane fill, dataInput180 → lane fill+1; fill += 2. fill is always even in this mode.
- Completion: when fill reaches LANES, the assembled word is copied to dataOutput, dataValid pulses, and fill returns to 0.
- Flush with fill > 0: lanes ≥ fill are driven zero in dataOutput, dataValid pulses, and fill returns to 0.
- Flush with fill = 0: nothing is emitted.
- Flush and sampleEnable in the same cycle: the sample is captured first, then the word is emitted (partial or full) once. Never two strobes.
- No backpressure. The consumer must accept every strobe.
- Lane buffer contents beyond fill are don't-care internally. They must not leak to dataOutput on flush.
- With PACK = 1, demuxMode = 1: one word per enabled cycle, equal to {dataInput180, dataInput} registered. This is the legacy 32-bit behaviour.

## Timing
- Reset (async assert, sync-safe deassert handled upstream):
  - dataOutput = 0, dataValid = 0, fill = 0, modeQ = 0.
  - Reset mid-word discards the partial word with no strobe.
- Latency is one clock, from the edge that captures the last lane (or samples flush) to dataValid high with dataOutput stable.
- dataOutput holds its value between strobes.
- dataValid is never high on two consecutive cycles unless words complete on consecutive cycles. That occurs only when LANES ≤ 2 in demux mode, or via flush.
- Max strobe rate is one per clock.

## Structure
- Shared package `ols_pkg`:
  - localparam function for LANES and the counter width $clog2(LANES+1)
  - mode encoding constants DEMUX_OFF = 1'b0, DEMUX_ON = 1'b1
- Single module. The lane buffer and the write-index mux are simple enough that no sub-module is warranted.
- Lane writes use a generate loop over LANES with per-lane write enables decoded from fill and modeQ.

## Test plan
- CHANNELS = 16, PACK = 2, demux on, sampleEnable high, inputs A1/B1 then A2/B2:
  - one strobe two cycles after the first capture
  - dataOutput = {B2, A2, B1, A1}
- Normal mode, samples 0x0001, 0x0002, 0x0003, 0x0004 over cycles with sampleEnable toggling 1, 0, 1, 1, 0, 1:
  - one strobe
  - dataOutput = 0x0004_0003_0002_0001
- Normal mode, two samples 0x00AA, 0x00BB, then flush:
  - strobe next cycle, dataOutput = 0x0000_0000_00BB_00AA
  - a second flush produces no strobe
- Flush and sampleEnable in the same cycle as the third normal-mode sample 0x00CC:
  - exactly one strobe, dataOutput = 0x0000_00CC_00BB_00AA
- demuxMode toggled 1→0 after the first pair of a word:
  - word completes in demux mode
  - the following word packs single samples
- resetN pulsed low with fill = 3:
  - dataValid and dataOutput go 0 immediately, no strobe
  - the next four samples form a clean word
- PACK = 1, demux on, sampleEnable high:
  - dataOutput = {dataInput180, dataInput}, one cycle late, strobe every cycle
